// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter sharing one 8N1 UART transmitter among NUM_REQ byte sources.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 framing).
module uart_tx_scheduler #(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int NUM_REQ    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       tx
);
    localparam int CPB = CLOCK_RATE / BAUD_RATE;
    localparam int CW  = $clog2(CPB);
    localparam int IW  = $clog2(NUM_REQ);
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, PARITY = 3'd4;
    localparam logic [2:0] AFTER_DATA = PARITY;
    logic [2:0] state_q, state_d;
    logic       par_q, par_d;
`else
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
    localparam logic [1:0] AFTER_DATA = STOP;
    logic [1:0] state_q, state_d;
`endif
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [IW-1:0] ptr_q, ptr_d, gid_q, gid_d, sel, idx;
    logic          found, go, bit_end, tx_q, tx_d;

    always_comb begin
        found = 1'b0;
        sel = '0;
        idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IW'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel = idx;
            end
        end
        // gated by rst_n so no grant can be issued while reset is held
        go = rst_n && state_q == IDLE && found;
        gnt = '0;
        gnt[sel] = go;
        bit_end = cnt_q == CW'(CPB - 1);
        cnt_d = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
        state_d = state_q;
        bit_d = bit_q;
        shift_d = shift_q;
        ptr_d = ptr_q;
        gid_d = gid_q;
`ifdef UART_TX_PARITY_EN
        par_d = par_q;
`endif
        case (state_q)
            IDLE: if (go) begin
                state_d = START;
                shift_d = req_data[8*sel +: 8];
                gid_d = sel;
                ptr_d = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
`ifdef UART_TX_PARITY_EN
                par_d = ^req_data[8*sel +: 8];
`endif
            end
            START: state_d = bit_end ? DATA : START;
            DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                bit_d = bit_q + 1'b1;
                state_d = (bit_q == 3'd7) ? AFTER_DATA : DATA;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: state_d = bit_end ? STOP : PARITY;
`endif
            default: state_d = bit_end ? IDLE : STOP;
        endcase
        // line level follows the next state so tx stays a plain register
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
`ifdef UART_TX_PARITY_EN
        if (state_d == PARITY) tx_d = par_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            ptr_q <= '0;
            gid_q <= '0;
            tx_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            ptr_q <= ptr_d;
            gid_q <= gid_d;
            tx_q <= tx_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else par_q <= par_d;
    end
`endif

    assign grant_id = gid_q;
    assign busy = state_q != IDLE;
    assign tx = tx_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: table vectors, directed corner sequences and random traffic against a frame-position model.
module tb_uart_tx_scheduler;
    localparam int CPB = 16;
    localparam int NR  = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    typedef struct {
        logic [NR-1:0] add;
        logic [7:0]    data;
        int            id;
    } vec_t;

    logic          clk = 1'b0, rst_n = 1'b1;
    logic [NR-1:0] req = '0, gnt, eg = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [1:0]    grant_id;
    logic          busy, tx;
    logic [7:0]    cur_b = '0;
    int total = 0, bad = 0, cyc = 0, pos = 0, ptr = 0, gid = 0, last_g = 0;
    vec_t tbl[8];

    uart_tx_scheduler #(.CLOCK_RATE(16), .BAUD_RATE(1), .NUM_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .gnt(gnt), .grant_id(grant_id), .busy(busy), .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // first pending requester at or after the pointer, as a one-hot mask
    function automatic logic [NR-1:0] pick(input logic [NR-1:0] r, input int p);
        logic [NR-1:0] m;
        for (int k = 0; k < NR; k++) begin
            m = '0;
            m[(p + k) % NR] = 1'b1;
            if ((r & m) != 0) return m;
        end
        return '0;
    endfunction

    // expected line level p cycles into a frame (0 = idle)
    function automatic logic etx(input int p, input logic [7:0] b);
        int bi;
        if (p == 0) return 1'b1;
        bi = (p - 1) / CPB;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return b[bi-1];
        if (NBITS == 11 && bi == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic step();
        #1;
        eg = (pos == 0) ? pick(req, ptr) : '0;
        chk("gnt", gnt, eg);
        @(posedge clk);
        cyc++;
        if (eg != 0) begin
            for (int i = 0; i < NR; i++)
                if (eg[i]) begin
                    gid = i;
                    cur_b = req_data[8*i +: 8];
                end
            ptr = (gid + 1) % NR;
            pos = 1;
        end else if (pos > 0) pos = (pos == FRAME) ? 0 : pos + 1;
        @(negedge clk);
        chk("tx", tx, etx(pos, cur_b));
        chk("busy", busy, pos > 0);
        chk("grant_id", grant_id, gid);
    endtask

    task automatic wait_grant(input string name, input int limit, output int id);
        id = -1;
        for (int n = 0; n < limit && id < 0; n++) begin
            step();
            if (eg != 0) begin
                id = gid;
                last_g = cyc;
                req = req & ~eg;
            end
        end
        chk(name, id < 0, 0);
    endtask

    task automatic wait_idle(output int nbusy);
        nbusy = int'(busy);
        for (int n = 0; n < 2 * FRAME && pos != 0; n++) begin
            step();
            if (busy) nbusy++;
        end
        chk("idle_timeout", pos, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_gid", grant_id, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pos = 0;
        ptr = 0;
        gid = 0;
    endtask

    task automatic run_to(input int p);
        for (int n = 0; n < 2 * FRAME && pos != p; n++) step();
        chk("run_to_timeout", pos, p);
    endtask

    initial begin
        int id, nb, prev;
        tbl[0] = '{4'b0100, 8'hA5, 2};
        tbl[1] = '{4'b1000, 8'h5A, 3};
        tbl[2] = '{4'b0101, 8'h3C, 0};
        tbl[3] = '{4'b0000, 8'hC3, 2};
        tbl[4] = '{4'b0110, 8'h01, 1};
        tbl[5] = '{4'b0011, 8'hFE, 2};
        tbl[6] = '{4'b0000, 8'h80, 0};
        tbl[7] = '{4'b0000, 8'h7F, 1};
        @(negedge clk);
        do_reset();
        repeat (3) step();
        foreach (tbl[i]) begin
            req = req | tbl[i].add;
            req_data = {NR{tbl[i].data}};
            wait_grant("tbl_grant", 4 * FRAME, id);
            chk("tbl_gid", grant_id, tbl[i].id);
            wait_idle(nb);
            chk("tbl_busy_len", nb, FRAME);
        end
        // full contention from a reset pointer
        do_reset();
        req = '1;
        req_data = 32'h11_22_33_44;
        for (int g = 0; g < 5; g++) begin
            prev = last_g;
            wait_grant("cont_grant", 2 * FRAME, id);
            chk("cont_gid", grant_id, g % NR);
            if (g > 0) chk("cont_pitch", last_g - prev, FRAME + 1);
            req = '1;
        end
        req = '0;
        wait_idle(nb);
        // request withdrawn while busy
        req = 4'b0001;
        wait_grant("wd_grant", 2 * FRAME, id);
        repeat (10) step();
        req[1] = 1'b1;
        repeat (5) step();
        req[1] = 1'b0;
        wait_idle(nb);
        repeat (3) begin
            step();
            chk("wd_tx", tx, 1);
            chk("wd_busy", busy, 0);
            chk("wd_gnt", gnt, 0);
        end
        // reset in the middle of data bit 4 (a zero bit of 8'hEF)
        req = 4'b0100;
        req_data = {NR{8'hEF}};
        wait_grant("mid_grant", 2 * FRAME, id);
        run_to(1 + 5 * CPB + 3);
        chk("mid_pre_tx", tx, 0);
        do_reset();
        req = 4'b1010;
        wait_grant("mid_after1", 2 * FRAME, id);
        chk("mid_first_gid", grant_id, 1);
        wait_idle(nb);
        wait_grant("mid_after2", 2 * FRAME, id);
        chk("mid_second_gid", grant_id, 3);
        wait_idle(nb);
`ifdef UART_TX_PARITY_EN
        req = 4'b0001;
        req_data = {NR{8'h07}};
        wait_grant("par_grant1", 2 * FRAME, id);
        run_to(1 + 9 * CPB + 2);
        chk("par_07", tx, 1);
        wait_idle(nb);
        chk("par_frame_len", nb, 176);
        req = 4'b0010;
        req_data = {NR{8'h03}};
        wait_grant("par_grant2", 2 * FRAME, id);
        run_to(1 + 9 * CPB + 2);
        chk("par_03", tx, 0);
        wait_idle(nb);
`endif
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req[i] && $urandom_range(0, 99) < 4) begin
                    req[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end else if (req[i] && $urandom_range(0, 199) == 0) req[i] = 1'b0;
                else if ($urandom_range(0, 9) == 0) req_data[8*i +: 8] = 8'($urandom);
            end
            step();
            req = req & ~eg;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
